ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-slot instruction fetch stage.
// Holds a PC, issues one fetch request per free IR slot and buffers the
// returned word (plus its address) for decode. A redirect flushes the slot
// and reloads the PC. The redirect wins over any fetch or consume in that cycle.
module ifetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_ADDR,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RDEN,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DOUT,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_VALID,
  input  logic        IR_READY,
  output logic [31:0] FETCH_CNT
);

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic slot_free;
  logic fetch_done;
  logic consume;

  // Target addresses are word aligned; the low two bits are dropped here.
  logic unused_redirect_low;
  assign unused_redirect_low = ^REDIRECT_ADDR[1:0];

  // The slot can accept a new word if it is empty or is being drained now.
  assign slot_free  = !ir_valid_q || IR_READY;
  assign consume    = ir_valid_q && IR_READY;
  // Fetch request depends on the live redirect so a flushed cycle never
  // commits a memory access.
  assign MEM_RDEN   = (state_q == FETCH) && slot_free && !REDIRECT;
  assign fetch_done = MEM_RDEN && MEM_ACK;

  assign MEM_ADDR  = pc_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = ir_valid_q;
  assign FETCH_CNT = fetch_cnt_q;

  // Next-state: BOOT lasts one cycle, then redirect > fetch > consume.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (REDIRECT) begin
          pc_d       = {REDIRECT_ADDR[31:2], 2'b00};
          ir_d       = NOP_INSTR;
          ir_valid_d = 1'b0;
        end else if (fetch_done) begin
          ir_d        = MEM_DOUT;
          ir_pc_d     = pc_q;
          ir_valid_d  = 1'b1;
          pc_d        = pc_q + 32'd4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else if (consume) begin
          ir_d       = NOP_INSTR;
          ir_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      ir_q        <= NOP_INSTR;
      ir_pc_q     <= RESET_VEC;
      ir_valid_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule
